// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pkg
// Description : Shared definitions for the serial_port UART peripheral:
//               FSM state encoding, status bit indices, register offsets.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

  // Common state encoding used by both the TX and RX sequencers
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } serial_state_t;

  // Status register bit positions
  localparam int TX_BUSY  = 0;
  localparam int RX_READY = 1;
  localparam int OVR      = 2;
  localparam int FERR     = 3;
  localparam int PERR     = 4;

  // Register offsets relative to BASE_ADDR
  localparam int DATA_OFS = 0;
  localparam int STAT_OFS = 1;

endpackage
`default_nettype wire

// File: rtl/serial_fifo.sv
`default_nettype none
// ============================================================================
// Module      : serial_fifo
// Description : Small synchronous byte FIFO for received characters. A pop
//               on a full FIFO frees the slot for a simultaneous push.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/serial_port.sv
`default_nettype none
// ============================================================================
// Module      : serial_port
// Description : Bus-attached UART. Data register at BASE_ADDR (write = send,
//               read = pop RX FIFO), status register at BASE_ADDR+1.
//               Optional even parity enabled by macro SERIAL_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_port
  import serial_pkg::*;
#(
  parameter int         CLK_DIV    = 16,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] BASE_ADDR  = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire  [15:0] bus,
  input  logic [7:0]  addr,
  input  logic        DI,
  input  logic        DO,
  output logic        tx,
  input  logic        rx
);

  localparam int          CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [7:0]  DATA_ADDR = BASE_ADDR + 8'(DATA_OFS);
  localparam logic [7:0]  STAT_ADDR = BASE_ADDR + 8'(STAT_OFS);

  logic        sel_data_rd, sel_stat_rd, sel_data_wr;
  logic        fifo_push, fifo_empty, fifo_full;
  logic [7:0]  fifo_dout;
  logic        ovr, ferr, set_ferr;
  logic        tx_busy;
  logic [15:0] stat_val, rd_val;
  logic        unused_bus_hi;

  assign sel_data_rd   = DO && (addr == DATA_ADDR);
  assign sel_stat_rd   = DO && (addr == STAT_ADDR);
  assign sel_data_wr   = DI && (addr == DATA_ADDR);
  assign unused_bus_hi = ^bus[15:8];

  // ---------------------------------------------------------------- TX path
  serial_state_t tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_shift, tx_shift_n;
`ifdef SERIAL_PARITY_EN
  logic          tx_par, tx_par_n;
`endif

  assign tx_busy = (tx_state != S_IDLE);

  // TX state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
`ifdef SERIAL_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
`ifdef SERIAL_PARITY_EN
      tx_par   <= tx_par_n;
`endif
    end
  end

  // TX next-state and line output; each non-idle state lasts CLK_DIV cycles
  always_comb begin
    tx_state_n = tx_state;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_cnt_n   = (tx_cnt == BIT_LAST) ? '0 : tx_cnt + 1'b1;
`ifdef SERIAL_PARITY_EN
    tx_par_n   = tx_par;
`endif
    tx         = 1'b1;
    case (tx_state)
      S_IDLE: begin
        tx_cnt_n = '0;
        if (sel_data_wr) begin
          tx_state_n = S_START;
          tx_shift_n = bus[7:0];
`ifdef SERIAL_PARITY_EN
          tx_par_n   = ^bus[7:0];
`endif
        end
      end
      S_START: begin
        tx = 1'b0;
        if (tx_cnt == BIT_LAST) begin
          tx_state_n = S_DATA;
          tx_bit_n   = '0;
        end
      end
      S_DATA: begin
        tx = tx_shift[0];
        if (tx_cnt == BIT_LAST) begin
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_bit_n   = tx_bit + 1'b1;
          if (tx_bit == 3'd7) begin
`ifdef SERIAL_PARITY_EN
            tx_state_n = S_PARITY;
`else
            tx_state_n = S_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_PARITY_EN
      S_PARITY: begin
        tx = tx_par;
        if (tx_cnt == BIT_LAST) tx_state_n = S_STOP;
      end
`endif
      S_STOP: begin
        if (tx_cnt == BIT_LAST) tx_state_n = S_IDLE;
      end
      default: tx_state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX path
  serial_state_t rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          rx_meta, rx_sync, rx_prev;
`ifdef SERIAL_PARITY_EN
  logic          rx_perr, rx_perr_n, set_perr, perr;
`endif

  // Two-flop synchroniser plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
`ifdef SERIAL_PARITY_EN
      rx_perr  <= 1'b0;
`endif
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
`ifdef SERIAL_PARITY_EN
      rx_perr  <= rx_perr_n;
`endif
    end
  end

  // RX next-state: validate start at mid-bit, then sample once per bit period
  always_comb begin
    rx_state_n = rx_state;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_cnt_n   = (rx_cnt == BIT_LAST) ? '0 : rx_cnt + 1'b1;
    fifo_push  = 1'b0;
    set_ferr   = 1'b0;
`ifdef SERIAL_PARITY_EN
    rx_perr_n  = rx_perr;
    set_perr   = 1'b0;
`endif
    case (rx_state)
      S_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_sync) rx_state_n = S_START;
      end
      S_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 1'b1;
          if (rx_bit == 3'd7) begin
`ifdef SERIAL_PARITY_EN
            rx_state_n = S_PARITY;
`else
            rx_state_n = S_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_PARITY_EN
      S_PARITY: begin
        if (rx_cnt == BIT_LAST) begin
          rx_perr_n  = rx_sync ^ (^rx_shift);
          rx_state_n = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_state_n = S_IDLE;
          if (!rx_sync) begin
            set_ferr = 1'b1;
`ifdef SERIAL_PARITY_EN
          end else if (rx_perr) begin
            set_perr = 1'b1;
`endif
          end else begin
            fifo_push = 1'b1;
          end
        end
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  serial_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (sel_data_rd),
    .din   (rx_shift),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Sticky error flags: status read clears, a same-edge set takes precedence
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
`ifdef SERIAL_PARITY_EN
      perr <= 1'b0;
`endif
    end else begin
      if (sel_stat_rd) begin
        ovr  <= 1'b0;
        ferr <= 1'b0;
`ifdef SERIAL_PARITY_EN
        perr <= 1'b0;
`endif
      end
      if (fifo_push && fifo_full && !sel_data_rd) ovr <= 1'b1;
      if (set_ferr) ferr <= 1'b1;
`ifdef SERIAL_PARITY_EN
      if (set_perr) perr <= 1'b1;
`endif
    end
  end

  // Read-back mux for the bus
  always_comb begin
    stat_val           = '0;
    stat_val[TX_BUSY]  = tx_busy;
    stat_val[RX_READY] = !fifo_empty;
    stat_val[OVR]      = ovr;
    stat_val[FERR]     = ferr;
`ifdef SERIAL_PARITY_EN
    stat_val[PERR]     = perr;
`endif
    rd_val = sel_stat_rd ? stat_val : (fifo_empty ? 16'h0000 : {8'h00, fifo_dout});
  end

  assign bus = (sel_data_rd || sel_stat_rd) ? rd_val : {16{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_serial_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_port
// Description : Scoreboard testbench for serial_port (default 8N1 build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_port;

  localparam int         CLK_DIV    = 16;
  localparam int         FIFO_DEPTH = 4;
  localparam logic [7:0] BASE_ADDR  = 8'h00;
  localparam logic [7:0] A_DATA     = BASE_ADDR;
  localparam logic [7:0] A_STAT     = BASE_ADDR + 8'd1;
  localparam int         FRAME      = 10 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        DI = 1'b0;
  logic        DO = 1'b0;
  logic        rx = 1'b1;
  logic [7:0]  addr = 8'h00;
  logic        tx;
  logic        drv_en = 1'b0;
  logic [15:0] drv_val = 16'h0000;
  wire  [15:0] bus;

  assign bus = drv_en ? drv_val : {16{1'bz}};

  serial_port #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BASE_ADDR  (BASE_ADDR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .addr  (addr),
    .DI    (DI),
    .DO    (DO),
    .tx    (tx),
    .rx    (rx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0]  rxq[$];
  logic [7:0]  tx_exp_q[$];
  logic [15:0] rd_exp_q[$];
  bit          m_ovr = 1'b0;
  bit          m_ferr = 1'b0;
  int          last_w = -100000;
  bit          tx_mon_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // A transmitter that accepted a write at edge W is busy for the FRAME cycles after it
  function automatic bit busy_at(int c);
    return (c >= last_w) && (c <= last_w + FRAME - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(logic [7:0] a, logic [15:0] v);
    if (a == A_DATA && !busy_at(cyc)) begin
      last_w = cyc + 1;
      tx_exp_q.push_back(v[7:0]);
    end
  endtask

  task automatic model_read(logic [7:0] a);
    logic [15:0] e;
    if (a == A_STAT) begin
      e = {11'h000, 1'b0, m_ferr, m_ovr, (rxq.size() != 0), busy_at(cyc)};
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end else if (rxq.size() == 0) begin
      e = 16'h0000;
    end else begin
      e = {8'h00, rxq.pop_front()};
    end
    rd_exp_q.push_back(e);
  endtask

  task automatic model_reset();
    rxq.delete();
    tx_exp_q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    last_w = -100000;
  endtask

  task automatic bus_write(logic [7:0] a, logic [15:0] v);
    model_write(a, v);
    addr = a; drv_val = v; drv_en = 1'b1; DI = 1'b1;
    tick();
    DI = 1'b0; drv_en = 1'b0;
  endtask

  task automatic bus_read(logic [7:0] a);
    model_read(a);
    addr = a; DO = 1'b1;
    tick();
    DO = 1'b0;
  endtask

  task automatic send_rx(logic [7:0] b, bit stop);
    rx = 1'b0;
    repeat (CLK_DIV) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLK_DIV) tick();
    end
    rx = stop;
    repeat (CLK_DIV) tick();
    rx = 1'b1;
    repeat (4) tick();
    if (!stop)                          m_ferr = 1'b1;
    else if (rxq.size() == FIFO_DEPTH)  m_ovr  = 1'b1;
    else                                rxq.push_back(b);
  endtask

  // Bus read monitor
  initial begin
    forever begin
      @(negedge clk);
      if (DO && (addr == A_DATA || addr == A_STAT)) begin
        if (rd_exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rd_unexpected @cyc %0d: got %h expected no read", cyc, bus);
        end else begin
          check("bus_read", bus, rd_exp_q.pop_front());
        end
      end
    end
  end

  // Serial TX decoder: samples each bit at its centre
  initial begin : tx_mon
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (tx_mon_en && tx == 1'b0) begin
        repeat (CLK_DIV / 2 - 1) @(negedge clk);
        check("tx_start", tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          d[i] = tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        check("tx_stop", tx, 1);
        if (tx_exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL tx_unexpected @cyc %0d: got %h expected no frame", cyc, d);
        end else begin
          check("tx_byte", d, tx_exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] wbyte;
    logic       exp_tx;

    // Reset and idle
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_tx", tx, 1);
      tick();
    end
    bus_read(A_STAT);
    tx_mon_en = 1'b1;

    // Exact TX waveform for 0xA5, ignored second write, busy drop point
    wbyte = 8'hA5;
    bus_write(A_DATA, 16'h00A5);
    for (int i = 1; i <= 170; i++) begin
      if (i == 50) begin
        model_write(A_DATA, 16'h00FF);
        addr = A_DATA; drv_val = 16'h00FF; drv_en = 1'b1; DI = 1'b1;
      end
      if (i >= 159 && i <= 161) begin
        model_read(A_STAT);
        addr = A_STAT; DO = 1'b1;
      end
      if (i <= CLK_DIV)          exp_tx = 1'b0;
      else if (i <= 9 * CLK_DIV) exp_tx = wbyte[(i - CLK_DIV - 1) / CLK_DIV];
      else                       exp_tx = 1'b1;
      @(negedge clk);
      check("tx_wave", tx, exp_tx);
      tick();
      DI = 1'b0; DO = 1'b0; drv_en = 1'b0;
    end
    repeat (20) tick();

    // Single received byte
    send_rx(8'h3C, 1'b1);
    bus_read(A_STAT);
    bus_read(A_DATA);
    bus_read(A_DATA);
    bus_read(A_STAT);

    // Overflow: five frames into a four-entry FIFO
    for (int i = 0; i < 5; i++) send_rx(8'($urandom), 1'b1);
    bus_read(A_STAT);
    for (int i = 0; i < 5; i++) bus_read(A_DATA);
    bus_read(A_STAT);

    // Glitch rejection
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (3 * CLK_DIV) tick();
    bus_read(A_STAT);

    // Framing error
    send_rx(8'h55, 1'b0);
    bus_read(A_STAT);
    bus_read(A_STAT);

    // Randomised mix of traffic
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: send_rx(8'($urandom), ($urandom_range(0, 5) != 0));
        1: bus_read(A_DATA);
        2: bus_read(A_STAT);
        3: bus_write(A_DATA, 16'($urandom));
        default: bus_write(A_STAT, 16'($urandom));
      endcase
      repeat ($urandom_range(0, 20)) tick();
    end
    repeat (FRAME + 20) tick();
    for (int i = 0; i < FIFO_DEPTH; i++) bus_read(A_DATA);
    bus_read(A_STAT);

    // Reset in the middle of a transmission with a byte waiting in the FIFO
    send_rx(8'h81, 1'b1);
    tx_mon_en = 1'b0;
    bus_write(A_DATA, 16'h0033);
    repeat (39) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    model_read(A_STAT);
    addr = A_STAT; DO = 1'b1;
    @(negedge clk);
    check("rst_tx", tx, 1);
    tick();
    DO = 1'b0;

    // Transmitter works again after reset
    repeat (5) tick();
    tx_mon_en = 1'b1;
    bus_write(A_DATA, 16'h005A);
    repeat (FRAME + 20) tick();
    bus_read(A_STAT);
    repeat (5) tick();

    check("rd_queue_drained", rd_exp_q.size(), 0);
    check("tx_queue_drained", tx_exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
